// File: rtl/execution_sequencer.sv
// Instruction-level sequencer: fetch/decode/execute control with a micro-call return stack.
// The PC, microcode address, stack level, state and every strobe are registers.
module execution_sequencer #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned UADDR_WIDTH = 16,
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               halt,
    input  logic                               resume,
    input  logic                               fetch_ready,
    input  logic [UADDR_WIDTH-1:0]             entry_address,
    input  logic                               finish,
    input  logic                               jump_taken,
    input  logic [ADDRESS_WIDTH-1:0]           jump_address,
    input  logic                               call,
    input  logic [UADDR_WIDTH-1:0]             call_target,
    input  logic                               ret,
    input  logic                               stall,
    output logic [ADDRESS_WIDTH-1:0]           program_counter,
    output logic [UADDR_WIDTH-1:0]             microcode_address,
    output logic                               microcode_rom_read_enable,
    output logic                               fetch_request,
    output logic                               instruction_done,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic [2:0]                         state,
    output logic                               halted,
    output logic                               fault
);

    localparam int unsigned LW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned SLOTS = 1 << IW;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALTED  = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [UADDR_WIDTH-1:0] stack_mem [SLOTS];

    logic exec_go;
    logic do_finish;
    logic do_ret;
    logic do_call;
    logic stack_empty;
    logic stack_full;
    logic push_en;

    // Execute-cycle priority: finish beats ret beats call; stall masks everything.
    always_comb begin
        exec_go     = (state_q == S_EXECUTE) && !stall;
        do_finish   = exec_go && finish;
        do_ret      = exec_go && !finish && ret;
        do_call     = exec_go && !finish && !ret && call;
        stack_empty = (stack_level == '0);
        stack_full  = (stack_level == FULL_LEVEL);
        push_en     = do_call && !stack_full;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (enable) state_d = S_FETCH;
            S_FETCH:   if (fetch_ready) state_d = S_DECODE;
            S_DECODE:  state_d = halt ? S_HALTED : S_EXECUTE;
            S_EXECUTE: begin
                if (do_finish)                   state_d = enable ? S_FETCH : S_IDLE;
                else if (do_ret && stack_empty)  state_d = S_FAULT;
                else if (do_call && stack_full)  state_d = S_FAULT;
            end
            S_HALTED:  if (resume) state_d = S_FETCH;
            S_FAULT:   state_d = S_FAULT;
            default:   state_d = S_FAULT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q                   <= S_IDLE;
            program_counter           <= RESET_PC;
            microcode_address         <= '0;
            stack_level               <= '0;
            microcode_rom_read_enable <= 1'b0;
            fetch_request             <= 1'b0;
            instruction_done          <= 1'b0;
            halted                    <= 1'b0;
            fault                     <= 1'b0;
        end else begin
            state_q                   <= state_d;
            fetch_request             <= (state_d == S_FETCH);
            microcode_rom_read_enable <= (state_d == S_EXECUTE);
            halted                    <= (state_d == S_HALTED);
            fault                     <= (state_d == S_FAULT);
            instruction_done          <= do_finish;

            case (state_q)
                S_DECODE: begin
                    if (!halt) begin
                        microcode_address <= entry_address;
                        stack_level       <= '0;
                    end
                end
                S_EXECUTE: begin
                    if (do_finish) begin
                        program_counter <= jump_taken ? jump_address
                                                      : program_counter + ADDRESS_WIDTH'(1);
                        stack_level     <= '0;
                    end else if (do_ret) begin
                        if (!stack_empty) begin
                            microcode_address <= stack_mem[IW'(stack_level - LW'(1))];
                            stack_level       <= stack_level - LW'(1);
                        end
                    end else if (do_call) begin
                        if (!stack_full) begin
                            microcode_address <= call_target;
                            stack_level       <= stack_level + LW'(1);
                        end
                    end else if (exec_go) begin
                        microcode_address <= microcode_address + UADDR_WIDTH'(1);
                    end
                end
                S_HALTED: begin
                    if (resume) program_counter <= program_counter + ADDRESS_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // Return-address storage needs no reset; stack_level defines which entries are live.
    always_ff @(posedge clock) begin
        if (push_en) stack_mem[IW'(stack_level)] <= microcode_address + UADDR_WIDTH'(1);
    end

    assign state = state_q;

endmodule

// File: tb/tb_execution_sequencer.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based behavioural model.
module tb_execution_sequencer;

    localparam int unsigned AW = 16;
    localparam int unsigned UW = 16;
    localparam int unsigned DEPTH = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0, halt = 1'b0, resume = 1'b0, fetch_ready = 1'b0;
    logic [UW-1:0] entry_address = '0;
    logic          finish = 1'b0, jump_taken = 1'b0;
    logic [AW-1:0] jump_address = '0;
    logic          call = 1'b0;
    logic [UW-1:0] call_target = '0;
    logic          ret = 1'b0, stall = 1'b0;

    logic [AW-1:0] program_counter;
    logic [UW-1:0] microcode_address;
    logic          microcode_rom_read_enable, fetch_request, instruction_done;
    logic [1:0]    stack_level;
    logic [2:0]    state;
    logic          halted, fault;

    execution_sequencer #(
        .ADDRESS_WIDTH(AW), .UADDR_WIDTH(UW), .STACK_DEPTH(DEPTH), .RESET_PC(16'h0000)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .halt(halt), .resume(resume),
        .fetch_ready(fetch_ready), .entry_address(entry_address), .finish(finish),
        .jump_taken(jump_taken), .jump_address(jump_address), .call(call),
        .call_target(call_target), .ret(ret), .stall(stall),
        .program_counter(program_counter), .microcode_address(microcode_address),
        .microcode_rom_read_enable(microcode_rom_read_enable), .fetch_request(fetch_request),
        .instruction_done(instruction_done), .stack_level(stack_level), .state(state),
        .halted(halted), .fault(fault)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: phase name as an integer code, return stack as a queue.
    int            m_phase;
    logic [AW-1:0] m_pc;
    logic [UW-1:0] m_ua;
    logic [UW-1:0] m_stk[$];
    logic          m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pc    = '0;
        m_ua    = '0;
        m_stk.delete();
        m_done  = 1'b0;
    endtask

    task automatic model_step();
        m_done = 1'b0;
        case (m_phase)
            0: if (enable) m_phase = 1;
            1: if (fetch_ready) m_phase = 2;
            2: begin
                if (halt) m_phase = 4;
                else begin
                    m_ua = entry_address;
                    m_stk.delete();
                    m_phase = 3;
                end
            end
            3: if (!stall) begin
                if (finish) begin
                    m_pc = jump_taken ? jump_address : AW'((int'(m_pc) + 1) % 65536);
                    m_stk.delete();
                    m_done = 1'b1;
                    m_phase = enable ? 1 : 0;
                end else if (ret) begin
                    if (m_stk.size() == 0) m_phase = 5;
                    else m_ua = m_stk.pop_back();
                end else if (call) begin
                    if (m_stk.size() == DEPTH) m_phase = 5;
                    else begin
                        m_stk.push_back(UW'((int'(m_ua) + 1) % 65536));
                        m_ua = call_target;
                    end
                end else begin
                    m_ua = UW'((int'(m_ua) + 1) % 65536);
                end
            end
            4: if (resume) begin
                m_pc = AW'((int'(m_pc) + 1) % 65536);
                m_phase = 1;
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(state), 32'(m_phase));
        chk({tag, ".pc"}, 32'(program_counter), 32'(m_pc));
        chk({tag, ".uaddr"}, 32'(microcode_address), 32'(m_ua));
        chk({tag, ".level"}, 32'(stack_level), 32'(m_stk.size()));
        chk({tag, ".fetch_req"}, 32'(fetch_request), 32'(m_phase == 1));
        chk({tag, ".rom_re"}, 32'(microcode_rom_read_enable), 32'(m_phase == 3));
        chk({tag, ".done"}, 32'(instruction_done), 32'(m_done));
        chk({tag, ".halted"}, 32'(halted), 32'(m_phase == 4));
        chk({tag, ".fault"}, 32'(fault), 32'(m_phase == 5));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    // Reset takes effect without a clock edge, then is held across one edge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clock);
        #1;
        check_all({tag, ".held"});
        reset = 1'b0;
    endtask

    task automatic clear_ctl();
        finish = 1'b0; jump_taken = 1'b0; call = 1'b0; ret = 1'b0;
        stall = 1'b0; halt = 1'b0; resume = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clock);
        #1;
        do_reset("rst0");

        // Basic instruction: entry 0x10, finish on third execute cycle
        enable = 1'b1; fetch_ready = 1'b1; entry_address = 16'h0010;
        tick("b.fetch"); tick("b.decode"); tick("b.ex1");
        chk("b.ua0", 32'(microcode_address), 32'h10);
        tick("b.ex2"); tick("b.ex3");
        chk("b.ua2", 32'(microcode_address), 32'h12);
        finish = 1'b1;
        tick("b.fin");
        finish = 1'b0;
        chk("b.done", 32'(instruction_done), 32'h1);
        chk("b.pc1", 32'(program_counter), 32'h1);
        chk("b.back_fetch", 32'(state), 32'h1);
        tick("b.done_clr");
        chk("b.done_pulse", 32'(instruction_done), 32'h0);

        // Fetch wait states (already in DECODE after the previous tick, so loop once more)
        tick("w.dec"); entry_address = 16'h0020;
        finish = 1'b1; tick("w.ex"); finish = 1'b0;
        fetch_ready = 1'b0;
        tick("w.wait1"); tick("w.wait2"); tick("w.wait3");
        chk("w.still_fetch", 32'(state), 32'h1);
        fetch_ready = 1'b1;
        tick("w.ready");
        chk("w.decode", 32'(state), 32'h2);
        tick("w.exec");

        // finish wins over ret/call, with a jump
        call = 1'b1; call_target = 16'h0100;
        tick("p.call");
        call = 1'b0;
        finish = 1'b1; jump_taken = 1'b1; jump_address = 16'h0040; ret = 1'b1; call = 1'b1;
        tick("p.fin");
        clear_ctl();
        chk("p.pc", 32'(program_counter), 32'h40);
        chk("p.level", 32'(stack_level), 32'h0);
        chk("p.ua_kept", 32'(microcode_address), 32'h100);

        // Stack overflow with depth 2, fault is sticky
        tick("o.dec"); tick("o.ex");
        call = 1'b1; call_target = 16'h0200;
        tick("o.c1"); tick("o.c2"); tick("o.c3");
        chk("o.fault", 32'(fault), 32'h1);
        call = 1'b0; resume = 1'b1;
        tick("o.s1"); tick("o.s2"); tick("o.s3");
        chk("o.sticky", 32'(fault), 32'h1);
        clear_ctl();
        do_reset("o.rst");

        // Halt at PC 5, resume to PC 6
        enable = 1'b1; fetch_ready = 1'b1;
        tick("h.f"); tick("h.d"); tick("h.e");
        finish = 1'b1; jump_taken = 1'b1; jump_address = 16'h0005;
        tick("h.jmp");
        clear_ctl();
        tick("h.dec");
        halt = 1'b1;
        tick("h.halt");
        halt = 1'b0; enable = 1'b0;
        tick("h.h1"); tick("h.h2");
        chk("h.pc_frozen", 32'(program_counter), 32'h5);
        enable = 1'b1;
        tick("h.h3");
        resume = 1'b1;
        tick("h.resume");
        resume = 1'b0;
        chk("h.pc6", 32'(program_counter), 32'h6);
        chk("h.fetch", 32'(state), 32'h1);

        // PC wrap, then reset mid-execute while stalled
        tick("x.d"); tick("x.e");
        finish = 1'b1; jump_taken = 1'b1; jump_address = 16'hFFFF;
        tick("x.jmp");
        clear_ctl();
        tick("x.d2"); tick("x.e2");
        finish = 1'b1;
        tick("x.wrap");
        clear_ctl();
        chk("x.pc0", 32'(program_counter), 32'h0);
        tick("x.d3"); tick("x.e3");
        stall = 1'b1; ret = 1'b1; finish = 1'b1;
        tick("x.stall");
        do_reset("x.rst");
        clear_ctl();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            enable        = ($urandom_range(0, 9) < 8);
            halt          = ($urandom_range(0, 9) == 0);
            resume        = ($urandom_range(0, 9) < 3);
            fetch_ready   = ($urandom_range(0, 9) < 6);
            entry_address = UW'($urandom);
            finish        = ($urandom_range(0, 19) < 3);
            jump_taken    = $urandom_range(0, 1) == 1;
            jump_address  = AW'($urandom);
            call          = ($urandom_range(0, 9) < 2);
            call_target   = UW'($urandom);
            ret           = ($urandom_range(0, 19) < 3);
            stall         = ($urandom_range(0, 9) < 2);
            if (m_phase == 5 && $urandom_range(0, 3) == 0) do_reset("r.rst");
            else tick("r.step");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
